// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_t;

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/arb_resp_pipe.sv
// Tracks who owns each in-flight memory read and steers mem_rdata back to
// that requester exactly LATENCY cycles after the command.
module arb_resp_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  owner_t      owner,
    input  logic [31:0] mem_rdata,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        d_rvalid,
    output logic [31:0] d_rdata
);

    owner_t stage [LATENCY];
    owner_t tail;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) stage[i] <= OWN_NONE;
        end else begin
            stage[0] <= owner;
            for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    // Masked while reset is held so responses read 0 during the reset cycle itself.
    always_comb begin
        tail     = reset ? stage[LATENCY-1] : OWN_NONE;
        i_rvalid = (tail == OWN_INSTR);
        d_rvalid = (tail == OWN_DATA);
        i_rdata  = i_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter: data port wins, fetch is forced through after
// MAX_DATA_BURST consecutive data grants while fetch waits.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY    = 1,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(MAX_DATA_BURST + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;
    owner_t        owner;
    mem_cmd_t      cmd;

    always_comb begin
        starved = (starve_cnt == CW'(MAX_DATA_BURST));
        d_gnt   = reset && d_req && !(i_req && starved);
        i_gnt   = reset && i_req && !d_gnt;

        cmd = '0;
        if (d_gnt)      cmd = '{we: d_we, addr: d_addr, wdata: d_wdata};
        else if (i_gnt) cmd = '{we: 4'b0, addr: i_addr, wdata: 32'b0};

        mem_en    = i_gnt | d_gnt;
        mem_we    = cmd.we;
        mem_addr  = cmd.addr;
        mem_wdata = cmd.wdata;

        // Writes complete at grant, so only reads occupy a response slot.
        owner = OWN_NONE;
        if (i_gnt)                       owner = OWN_INSTR;
        else if (d_gnt && d_we == 4'b0)  owner = OWN_DATA;
    end

    always_ff @(posedge clk) begin
        if (!reset || i_gnt || !i_req)      starve_cnt <= '0;
        else if (d_gnt && !starved)         starve_cnt <= starve_cnt + 1'b1;
    end

    arb_resp_pipe #(.LATENCY(MEM_LATENCY)) u_resp (
        .clk      (clk),
        .reset    (reset),
        .owner    (owner),
        .mem_rdata(mem_rdata),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Three arbiters (MEM_LATENCY 1..3) each backed by a fixed-latency memory
// model; a scoreboard queue checks every read response by cycle and data.
module tb_mem_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [N-1:0]       i_req, d_req, i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en;
    logic [N-1:0][31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata;
    logic [N-1:0][31:0] mem_addr, mem_wdata, mem_rdata;
    logic [N-1:0][3:0]  d_we, mem_we;

    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_dut
        logic [31:0] dl [k+1];

        mem_arbiter #(.MEM_LATENCY(k + 1), .MAX_DATA_BURST(4)) u_dut (
            .clk      (clk),
            .reset    (rst_n),
            .i_req    (i_req[k]),
            .i_addr   (i_addr[k]),
            .i_gnt    (i_gnt[k]),
            .i_rvalid (i_rvalid[k]),
            .i_rdata  (i_rdata[k]),
            .d_req    (d_req[k]),
            .d_we     (d_we[k]),
            .d_addr   (d_addr[k]),
            .d_wdata  (d_wdata[k]),
            .d_gnt    (d_gnt[k]),
            .d_rvalid (d_rvalid[k]),
            .d_rdata  (d_rdata[k]),
            .mem_en   (mem_en[k]),
            .mem_we   (mem_we[k]),
            .mem_addr (mem_addr[k]),
            .mem_wdata(mem_wdata[k]),
            .mem_rdata(mem_rdata[k])
        );

        always @(posedge clk) begin
            dl[0] <= mem_word(mem_addr[k]);
            for (int j = 1; j <= k; j++) dl[j] <= dl[j-1];
        end
        assign mem_rdata[k] = dl[k];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < N; k++) begin
            if (i_rvalid[k]) begin
                if (iq.size() == 0) chk("i_rvalid_unexpected", 32'(k), 32'hFFFF_FFFF);
                else begin
                    e = iq.pop_front();
                    chk("i_resp_inst", 32'(k), 32'(e.inst));
                    chk("i_resp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("i_resp_data", i_rdata[k], e.data);
                end
            end else chk("i_rdata_idle_zero", i_rdata[k], 32'h0);
            if (d_rvalid[k]) begin
                if (dq.size() == 0) chk("d_rvalid_unexpected", 32'(k), 32'hFFFF_FFFF);
                else begin
                    e = dq.pop_front();
                    chk("d_resp_inst", 32'(k), 32'(e.inst));
                    chk("d_resp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("d_resp_data", d_rdata[k], e.data);
                end
            end else chk("d_rdata_idle_zero", d_rdata[k], 32'h0);
        end
    end

    initial begin : stim
        logic [5:0]  ipat;
        logic [31:0] fa [3];
        logic [31:0] fd [3];
        logic [9:0]  flags;

        ipat = 6'b010000;
        fa = '{32'h0, 32'h4, 32'h8};
        fd = '{32'h0000C0DE, 32'h0004C0DE, 32'h0008C0DE};

        // Reset held with both ports requesting
        i_req = '1; d_req = '1; d_we = '0;
        i_addr = '{default: 32'h100}; d_addr = '{default: 32'h2000}; d_wdata = '{default: 32'h55};
        repeat (3) begin
            step();
            #3;
            for (int k = 0; k < N; k++) begin
                flags = {i_gnt[k], d_gnt[k], i_rvalid[k], d_rvalid[k], mem_en[k],
                         |mem_we[k], |mem_addr[k], |mem_wdata[k], |i_rdata[k], |d_rdata[k]};
                chk("reset_outputs_zero", 32'(flags), 32'h0);
            end
        end
        step();
        rst_n = 1'b1; i_req = '0; d_req = '0;
        repeat (3) step();

        // Single fetch, latency 1
        i_req[0] = 1'b1; i_addr[0] = 32'h100;
        #3;
        chk("fetch_i_gnt", 32'(i_gnt[0]), 32'h1);
        chk("fetch_d_gnt", 32'(d_gnt[0]), 32'h0);
        chk("fetch_mem_en", 32'(mem_en[0]), 32'h1);
        chk("fetch_mem_addr", mem_addr[0], 32'h100);
        chk("fetch_mem_we", 32'(mem_we[0]), 32'h0);
        chk("fetch_mem_wdata", mem_wdata[0], 32'h0);
        iq.push_back('{0, cyc + 1, 32'hDEADBEEF});
        step();
        i_req[0] = 1'b0;
        #3;
        chk("idle_mem_en", 32'(mem_en[0]), 32'h0);
        chk("idle_mem_addr", mem_addr[0], 32'h0);
        repeat (2) step();

        // Contention; fetch address changes while it waits
        i_req[0] = 1'b1; i_addr[0] = 32'h1FC;
        d_req[0] = 1'b1; d_we[0] = 4'b0; d_addr[0] = 32'h2000;
        #3;
        chk("cont_d_gnt", 32'(d_gnt[0]), 32'h1);
        chk("cont_i_gnt_wait", 32'(i_gnt[0]), 32'h0);
        chk("cont_mem_addr_d", mem_addr[0], 32'h2000);
        dq.push_back('{0, cyc + 1, 32'h2000C0DE});
        step();
        d_req[0] = 1'b0; i_addr[0] = 32'h100;
        #3;
        chk("cont_i_gnt", 32'(i_gnt[0]), 32'h1);
        chk("cont_mem_addr_i", mem_addr[0], 32'h100);
        iq.push_back('{0, cyc + 1, 32'hDEADBEEF});
        step();
        i_req[0] = 1'b0;
        repeat (3) step();

        // Starvation: writes and fetch both held for six cycles
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            i_req[0] = 1'b1; i_addr[0] = 32'h100;
            d_req[0] = 1'b1; d_we[0] = 4'hF; d_addr[0] = 32'h80; d_wdata[0] = 32'hA5A5A5A5;
            #3;
            chk("starve_i_gnt", 32'(i_gnt[0]), 32'(ipat[i]));
            chk("starve_d_gnt", 32'(d_gnt[0]), 32'(!ipat[i]));
            if (ipat[i]) iq.push_back('{0, cyc + 1, 32'hDEADBEEF});
        end
        step();
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        repeat (3) step();

        // Byte write then back-to-back fetches, latency 3
        d_req[2] = 1'b1; d_we[2] = 4'b0011; d_addr[2] = 32'h40; d_wdata[2] = 32'h1234;
        #3;
        chk("wr_d_gnt", 32'(d_gnt[2]), 32'h1);
        chk("wr_mem_we", 32'(mem_we[2]), 32'h3);
        chk("wr_mem_addr", mem_addr[2], 32'h40);
        chk("wr_mem_wdata", mem_wdata[2], 32'h1234);
        for (int j = 0; j < 3; j++) begin
            step();
            d_req[2] = 1'b0;
            i_req[2] = 1'b1; i_addr[2] = fa[j];
            #3;
            chk("pipe_i_gnt", 32'(i_gnt[2]), 32'h1);
            chk("pipe_mem_addr", mem_addr[2], fa[j]);
            iq.push_back('{2, cyc + 3, fd[j]});
        end
        step();
        i_req[2] = 1'b0;
        repeat (5) step();

        // Reset while a latency-2 read is in flight
        d_req[1] = 1'b1; d_we[1] = 4'b0; d_addr[1] = 32'h2000;
        #3;
        chk("flight_d_gnt", 32'(d_gnt[1]), 32'h1);
        step();
        d_req[1] = 1'b0; rst_n = 1'b0;
        #3;
        chk("flight_rst_mem_en", 32'(mem_en[1]), 32'h0);
        step();
        rst_n = 1'b1;
        repeat (5) step();

        chk("sb_drain_i", 32'(iq.size()), 32'h0);
        chk("sb_drain_d", 32'(dq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
